// File: rtl/seq_scan_ctrl_if.sv
// Bus bundle for seq_scan_ctrl: scan request/config, serial data stream and result outputs.
// The controller uses the slave modport; the driving side uses the master modport.
interface seq_scan_ctrl_if #(
  parameter int TIMEOUT_W = 16
);
  logic                 start;
  logic                 abort;
  logic [7:0]           cfg_pattern;
  logic [7:0]           cfg_mask;
  logic [7:0]           cfg_target;
  logic [TIMEOUT_W-1:0] cfg_timeout;
  logic                 d_in;
  logic                 d_valid;
  logic                 busy;
  logic                 done;
  logic                 found;
  logic                 timeout;
  logic [7:0]           match_cnt;
  logic [TIMEOUT_W-1:0] bit_cnt;

  modport master (
    output start, abort, cfg_pattern, cfg_mask, cfg_target, cfg_timeout, d_in, d_valid,
    input  busy, done, found, timeout, match_cnt, bit_cnt
  );

  modport slave (
    input  start, abort, cfg_pattern, cfg_mask, cfg_target, cfg_timeout, d_in, d_valid,
    output busy, done, found, timeout, match_cnt, bit_cnt
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Serial pattern-scan controller: counts masked 8-bit window matches until a target count or bit timeout.
// Optional macro SEQ_SCAN_NONOVERLAP_EN makes matches non-overlapping (8 fresh bits per match).
module seq_scan_ctrl #(
  parameter int TIMEOUT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  seq_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, SCAN, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [7:0]           window;
  logic [2:0]           fill_cnt;
  logic [7:0]           pattern;
  logic [7:0]           mask;
  logic [7:0]           target;
  logic [TIMEOUT_W-1:0] timeout_lim;
  logic [7:0]           match_cnt;
  logic [TIMEOUT_W-1:0] bit_cnt;
  logic                 found;
  logic                 timed_out;

  logic                 active;
  logic                 accept;
  logic                 match;
  logic                 hit_target;
  logic                 hit_timeout;
  logic [7:0]           shifted;
  logic [7:0]           target_eff;
  logic [TIMEOUT_W-1:0] bit_cnt_inc;
  logic                 busy;
  logic                 done;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Abort masks acceptance, so it also wins over a same-cycle match or timeout.
  always_comb begin
    active      = (state == FILL) || (state == SCAN);
    accept      = active && bus.d_valid && !bus.abort;
    shifted     = {window[6:0], bus.d_in};
    target_eff  = (target == 8'd0) ? 8'd1 : target;
    bit_cnt_inc = (&bit_cnt) ? bit_cnt : bit_cnt + TIMEOUT_W'(1);
    match       = accept && (state == SCAN) && (((shifted ^ pattern) & mask) == 8'h00);
    hit_target  = match && ((match_cnt + 8'd1) == target_eff);
    hit_timeout = accept && (timeout_lim != '0) && (bit_cnt_inc == timeout_lim);
    busy        = active;
    done        = (state == DONE);
    state_next  = state;
    case (state)
      IDLE: if (bus.start) state_next = FILL;
      FILL: begin
        if (bus.abort)                        state_next = IDLE;
        else if (accept && hit_timeout)       state_next = DONE;
        else if (accept && fill_cnt == 3'd6)  state_next = SCAN;
      end
      SCAN: begin
        if (bus.abort)                        state_next = IDLE;
        else if (hit_target || hit_timeout)   state_next = DONE;
`ifdef SEQ_SCAN_NONOVERLAP_EN
        else if (match)                       state_next = FILL;
`endif
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Found and timeout are only ever set on the edge into DONE, so they read 0 during a scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      window      <= '0;
      fill_cnt    <= '0;
      pattern     <= '0;
      mask        <= '0;
      target      <= '0;
      timeout_lim <= '0;
      match_cnt   <= '0;
      bit_cnt     <= '0;
      found       <= 1'b0;
      timed_out   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      pattern     <= bus.cfg_pattern;
      mask        <= bus.cfg_mask;
      target      <= bus.cfg_target;
      timeout_lim <= bus.cfg_timeout;
      window      <= '0;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      bit_cnt     <= '0;
      found       <= 1'b0;
      timed_out   <= 1'b0;
    end else if (accept) begin
      window  <= shifted;
      bit_cnt <= bit_cnt_inc;
      if (state == FILL) fill_cnt <= fill_cnt + 3'd1;
      if (match)         match_cnt <= match_cnt + 8'd1;
      if (hit_target)       found     <= 1'b1;
      else if (hit_timeout) timed_out <= 1'b1;
`ifdef SEQ_SCAN_NONOVERLAP_EN
      if (match && !hit_target && !hit_timeout) fill_cnt <= '0;
`endif
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.found     = found;
  assign bus.timeout   = timed_out;
  assign bus.match_cnt = match_cnt;
  assign bus.bit_cnt   = bit_cnt;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl; expectations are hand-derived per scenario.
// Honours SEQ_SCAN_NONOVERLAP_EN for the overlap scenario.
module tb_seq_scan_ctrl;

  localparam int TIMEOUT_W = 16;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  seq_scan_ctrl_if #(.TIMEOUT_W(TIMEOUT_W)) bus ();

  seq_scan_ctrl #(.TIMEOUT_W(TIMEOUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic din, input logic dv);
    bus.d_in    = din;
    bus.d_valid = dv;
    tick();
    bus.d_valid = 1'b0;
  endtask

  // Config is scrambled after the start cycle to prove it was latched.
  task automatic startScan(input logic [7:0] p, input logic [7:0] m, input logic [7:0] t,
                           input logic [TIMEOUT_W-1:0] to);
    bus.cfg_pattern = p;
    bus.cfg_mask    = m;
    bus.cfg_target  = t;
    bus.cfg_timeout = to;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
    bus.cfg_pattern = ~p;
    bus.cfg_mask    = ~m;
    bus.cfg_target  = ~t;
    bus.cfg_timeout = ~to;
  endtask

  initial begin
    logic [7:0] stream;
    int         latency;
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    bus.start       = 1'b1;
    bus.abort       = 1'b0;
    bus.d_in        = 1'b1;
    bus.d_valid     = 1'b1;
    bus.cfg_pattern = 8'h55;
    bus.cfg_mask    = 8'hFF;
    bus.cfg_target  = 8'd1;
    bus.cfg_timeout = '0;
    tick();
    tick();
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_found", bus.found, 0);
    checkOutput("rst_timeout", bus.timeout, 0);
    checkOutput("rst_match_cnt", bus.match_cnt, 0);
    checkOutput("rst_bit_cnt", bus.bit_cnt, 0);
    bus.d_valid = 1'b0;

    $display("[TB] basic match 0x55");
    reset = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.cfg_pattern = 8'hAA;
    checkOutput("start_after_reset_busy", bus.busy, 1);
    stream = 8'b01010101;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(stream[7-i], 1'b1);
      if (i == 6) checkOutput("basic_bit7_done", bus.done, 0);
    end
    checkOutput("basic_done", bus.done, 1);
    checkOutput("basic_found", bus.found, 1);
    checkOutput("basic_match_cnt", bus.match_cnt, 1);
    checkOutput("basic_bit_cnt", bus.bit_cnt, 8);
    checkOutput("basic_busy", bus.busy, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("basic_done_pulse", bus.done, 0);
    checkOutput("basic_found_hold", bus.found, 1);

    $display("[TB] overlapping matches 0xAA target 3");
    startScan(8'hAA, 8'hFF, 8'd3, '0);
    checkOutput("start_clears_found", bus.found, 0);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(i[0], 1'b1);
`ifdef SEQ_SCAN_NONOVERLAP_EN
      if (i == 10) checkOutput("ovl_cnt_bit10", bus.match_cnt, 1);
`else
      if (i == 10) checkOutput("ovl_cnt_bit10", bus.match_cnt, 2);
`endif
    end
`ifdef SEQ_SCAN_NONOVERLAP_EN
    checkOutput("novl_done_bit12", bus.done, 0);
    for (int i = 13; i <= 16; i++) applyStimulus(i[0], 1'b1);
    checkOutput("novl_cnt_bit16", bus.match_cnt, 2);
    checkOutput("novl_busy_bit16", bus.busy, 1);
    bus.abort = 1'b1;
    applyStimulus(1'b0, 1'b0);
    bus.abort = 1'b0;
`else
    checkOutput("ovl_done", bus.done, 1);
    checkOutput("ovl_found", bus.found, 1);
    checkOutput("ovl_match_cnt", bus.match_cnt, 3);
    checkOutput("ovl_bit_cnt", bus.bit_cnt, 12);
    applyStimulus(1'b0, 1'b0);
`endif

    $display("[TB] timeout after 20 zero bits");
    startScan(8'hFF, 8'hFF, 8'd1, 16'd20);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (i == 19) begin
        checkOutput("to_bit19_done", bus.done, 0);
        checkOutput("to_bit19_cnt", bus.bit_cnt, 19);
      end
    end
    checkOutput("to_done", bus.done, 1);
    checkOutput("to_timeout", bus.timeout, 1);
    checkOutput("to_found", bus.found, 0);
    checkOutput("to_match_cnt", bus.match_cnt, 0);
    checkOutput("to_bit_cnt", bus.bit_cnt, 20);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] match and timeout on the same bit");
    startScan(8'h0F, 8'h0F, 8'd1, 16'd8);
    checkOutput("start_clears_timeout", bus.timeout, 0);
    stream = 8'b10101111;
    for (int i = 0; i < 8; i++) applyStimulus(stream[7-i], 1'b1);
    checkOutput("tie_done", bus.done, 1);
    checkOutput("tie_found", bus.found, 1);
    checkOutput("tie_timeout", bus.timeout, 0);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] abort after 5 bits");
    startScan(8'h55, 8'hFF, 8'd1, '0);
    checkOutput("abort_start_found", bus.found, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
    bus.abort = 1'b1;
    applyStimulus(1'b1, 1'b1);
    bus.abort = 1'b0;
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_bit_cnt", bus.bit_cnt, 5);
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort_no_done", bus.done, 0);

    $display("[TB] start during SCAN is ignored");
    startScan(8'hFF, 8'hFF, 8'd2, '0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("scan_start_cnt1", bus.match_cnt, 1);
    bus.cfg_pattern = 8'h00;
    bus.cfg_target  = 8'd1;
    bus.start       = 1'b1;
    applyStimulus(1'b1, 1'b1);
    bus.start       = 1'b0;
    checkOutput("scan_start_done", bus.done, 1);
    checkOutput("scan_start_match_cnt", bus.match_cnt, 2);
    checkOutput("scan_start_bit_cnt", bus.bit_cnt, 9);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] reset mid-SCAN");
    startScan(8'hFF, 8'hFF, 8'd5, '0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("midrst_pre_cnt", bus.match_cnt, 2);
    reset     = 1'b1;
    bus.start = 1'b1;
    applyStimulus(1'b1, 1'b1);
    reset     = 1'b0;
    bus.start = 1'b0;
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_match_cnt", bus.match_cnt, 0);
    checkOutput("midrst_bit_cnt", bus.bit_cnt, 0);
    checkOutput("midrst_found", bus.found, 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midrst_stays_idle", bus.busy, 0);

    $display("[TB] d_valid toggling");
    startScan(8'h55, 8'hFF, 8'd1, '0);
    stream  = 8'b01010101;
    latency = -1;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0 && k < 16) applyStimulus(stream[7-(k/2)], 1'b1);
      else                      applyStimulus(~stream[7-((k/2)%8)], 1'b0);
      if (bus.done) begin
        latency = k + 1;
        break;
      end
    end
    checkOutput("toggle_latency", latency, 15);
    checkOutput("toggle_found", bus.found, 1);
    checkOutput("toggle_match_cnt", bus.match_cnt, 1);
    checkOutput("toggle_bit_cnt", bus.bit_cnt, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 16, width of bit counter and timeout limit.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a scan; latches all cfg_* inputs.
REQ-005 SHALL have port abort  input  1  cancels an active scan.
REQ-006 SHALL have port cfg_pattern  input  8  target bit pattern; bit 7 is the oldest bit.
REQ-007 SHALL have port cfg_mask  input  8  1 = compare this position, 0 = don't-care.
REQ-008 SHALL have port cfg_target  input  8  number of matches required to finish; 0 treated as 1.
REQ-009 SHALL have port cfg_timeout  input  TIMEOUT_W  max accepted bits per scan; 0 = no timeout.
REQ-010 SHALL have port d_in  input  1  serial data bit.
REQ-011 SHALL have port d_valid  input  1  qualifies d_in; one bit accepted per cycle when high in FILL/SCAN.
REQ-012 SHALL have port busy  output  1  high in FILL or SCAN.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a scan completes (found or timeout).
REQ-014 SHALL have port found  output  1  sticky: last scan reached cfg_target matches.
REQ-015 SHALL have port timeout  output  1  sticky: last scan hit cfg_timeout first.
REQ-016 SHALL have port match_cnt  output  8  matches counted in the current/last scan.
REQ-017 SHALL have port bit_cnt  output  TIMEOUT_W  accepted bits in the current/last scan, saturating.

Function
REQ-018 SHALL implement states IDLE, FILL, SCAN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-019 SHALL accept start only in IDLE; start in FILL/SCAN/DONE is ignored without side effects.
REQ-020 SHALL, on accepted start: latch cfg_*, clear window, match_cnt, bit_cnt, found, timeout, fill count; enter FILL next cycle.
REQ-021 SHALL, in FILL/SCAN with d_valid=1, shift window <= {window[6:0], d_in} and increment bit_cnt (saturating at all-ones).
REQ-022 SHALL move FILL->SCAN after the 7th accepted bit, so the 8th accepted bit is the first compared.
REQ-023 SHALL detect a match combinationally on the accepting cycle when in SCAN and (({window[6:0], d_in} ^ pattern) & mask) == 0; match_cnt increments at that edge.
REQ-024 SHALL count overlapping matches (unless REQ-036 applies).
REQ-025 SHALL enter DONE with found=1 on the edge where match_cnt reaches max(cfg_target,1); match_cnt never exceeds the target.
REQ-026 SHALL enter DONE with timeout=1 on the edge where bit_cnt reaches nonzero cfg_timeout without target reached.
REQ-027 SHALL give found priority when target and timeout are reached on the same bit: found=1, timeout=0.
REQ-028 SHALL assert done only during the DONE cycle; found/timeout/match_cnt/bit_cnt hold until next accepted start or reset.
REQ-029 SHALL, on abort in FILL/SCAN, return to IDLE next edge with done=0, found=0, timeout=0; counters hold their values; abort in IDLE/DONE has no effect.
REQ-030 SHALL give abort priority over a same-cycle match or timeout event.
REQ-031 SHALL ignore d_in while d_valid=0 and in IDLE/DONE.

Reset
REQ-032 SHALL, with reset high at an edge, force IDLE and clear window, fill count, busy, done, found, timeout, match_cnt, bit_cnt, and latched cfg registers to 0.
REQ-033 SHALL give reset priority over start, abort and d_valid, including mid-scan.
REQ-034 SHALL not accept start on the reset cycle; start is accepted on the first cycle after reset deasserts.

Configuration
REQ-035 SHALL, without SEQ_SCAN_NONOVERLAP_EN defined, count overlapping matches as in REQ-024.
REQ-036 SHALL, with SEQ_SCAN_NONOVERLAP_EN defined, return SCAN->FILL and clear fill count after each non-final match, so the next match needs 8 fresh bits.

Verification
REQ-037 SHALL cover: pattern 0x55, mask 0xFF, target 1, timeout 0, stream 01010101 -> match on 8th bit, done pulse next edge, found=1, match_cnt=1, bit_cnt=8.
REQ-038 SHALL cover: pattern 0xAA, mask 0xFF, target 3, stream 1010101010 -> found after bit 12 (overlap default); bit 10 then bit 12 with NONOVERLAP_EN defined gives match_cnt=2 at bit 16 instead of found at bit 12.
REQ-039 SHALL cover: pattern 0xFF, timeout 20, all-zero stream -> done and timeout=1 at bit_cnt=20, found=0, match_cnt=0.
REQ-040 SHALL cover: pattern 0x0F, mask 0x0F, target 1, timeout 8, stream 10101111 -> match and timeout both on bit 8; found=1, timeout=0.
REQ-041 SHALL cover: abort after 5 bits -> IDLE, no done, busy=0, bit_cnt=5; start during SCAN ignored; reset mid-SCAN clears all outputs.
REQ-042 SHALL cover: d_valid toggling 1/0 every cycle with the REQ-037 stream -> identical result, done 15 cycles after the first accepted bit.
